// File: rtl/lf_pipe_addsub.sv
// Pipelined Ladner-Fischer adder/subtractor with valid/ready handshake, optional signed
// saturation and registered Cout/overflow/zero flags that travel with each beat.
module lf_pipe_addsub #(
  parameter int unsigned N          = 32,
  parameter int unsigned PIPE_EVERY = 2,
  parameter int unsigned SAT_EN     = 0
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         overflow,
  output logic         zero
);

  localparam int unsigned L = $clog2(N);
  localparam int unsigned S = (L + PIPE_EVERY - 1) / PIPE_EVERY;

  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  logic [N-1:0] b_eff;
  logic         cin_eff;
  assign b_eff   = sub ? ~B : B;
  assign cin_eff = sub | Cin;

  // Stage k holds group G/P entering prefix level k*PIPE_EVERY, plus the beat's side data.
  logic [N-1:0] g_q  [S];
  logic [N-1:0] gp_q [S];
  logic [N-1:0] p_q  [S];
  logic [S-1:0] vld_q, c0_q, msb_q;

  // tap_g/tap_p[k]: group G/P at the end of the levels owned by pipeline stage k.
  logic [N-1:0] tap_g [1:S];
  logic [N-1:0] tap_p [1:S];

  for (genvar l = 0; l < L; l++) begin : g_lvl
    logic [N-1:0] gi, pi, go, po;

    if (l % PIPE_EVERY == 0) begin : g_from_reg
      assign gi = g_q[l / PIPE_EVERY];
      assign pi = gp_q[l / PIPE_EVERY];
    end else begin : g_from_lvl
      assign gi = g_lvl[l-1].go;
      assign pi = g_lvl[l-1].po;
    end

    for (genvar i = 0; i < N; i++) begin : g_bit
      if (((i >> l) & 1) == 1) begin : g_black
        localparam int J = ((i >> l) << l) - 1;
        assign go[i] = gi[i] | (pi[i] & gi[J]);
        assign po[i] = pi[i] & pi[J];
      end else begin : g_pass
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end
    end

    if (((l + 1) % PIPE_EVERY == 0) || (l + 1 == L)) begin : g_tap
      assign tap_g[(l + PIPE_EVERY) / PIPE_EVERY] = go;
      assign tap_p[(l + PIPE_EVERY) / PIPE_EVERY] = po;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < S; k++) begin
        g_q[k]  <= '0;
        gp_q[k] <= '0;
        p_q[k]  <= '0;
      end
      vld_q <= '0;
      c0_q  <= '0;
      msb_q <= '0;
    end else if (en) begin
      g_q[0]   <= A & b_eff;
      gp_q[0]  <= A ^ b_eff;
      p_q[0]   <= A ^ b_eff;
      vld_q[0] <= in_valid;
      c0_q[0]  <= cin_eff;
      msb_q[0] <= A[N-1];
      for (int k = 1; k < S; k++) begin
        g_q[k]   <= tap_g[k];
        gp_q[k]  <= tap_p[k];
        p_q[k]   <= p_q[k-1];
        vld_q[k] <= vld_q[k-1];
        c0_q[k]  <= c0_q[k-1];
        msb_q[k] <= msb_q[k-1];
      end
    end
  end

  // Grey cells: fold the effective carry-in into every group prefix.
  logic [N:0]   c;
  logic [N-1:0] raw_sum, sat_sum, sum_c;
  logic         ovf_c;
  assign c[0]    = c0_q[S-1];
  assign c[N:1]  = tap_g[S] | (tap_p[S] & {N{c0_q[S-1]}});
  assign raw_sum = p_q[S-1] ^ c[N-1:0];
  assign ovf_c   = c[N] ^ c[N-1];
  assign sat_sum = msb_q[S-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  assign sum_c   = ((SAT_EN != 0) && ovf_c) ? sat_sum : raw_sum;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (en) begin
      out_valid <= vld_q[S-1];
      if (vld_q[S-1]) begin
        Sum      <= sum_c;
        Cout     <= c[N];
        overflow <= ovf_c;
        zero     <= (sum_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_lf_pipe_addsub.sv
// Scoreboard bench for lf_pipe_addsub (N=8, PIPE_EVERY=2): a wrapping and a saturating
// instance share one stimulus stream; expected results are queued at accept time.
module tb_lf_pipe_addsub;

  localparam int unsigned N = 8;

  typedef struct packed {
    logic [7:0] sum_w;
    logic [7:0] sum_s;
    logic       cout;
    logic       ovf;
    logic       zero_w;
    logic       zero_s;
  } exp_t;

  logic         clk, rst, in_valid, out_ready, Cin, sub;
  logic [N-1:0] A, B;
  logic         in_ready0, out_valid0, Cout0, ovf0, zero0;
  logic         in_ready1, out_valid1, Cout1, ovf1, zero1;
  logic [N-1:0] Sum0, Sum1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  int   streak = 0;
  int   max_streak = 0;
  logic bp_on;
  exp_t sb[$];

  lf_pipe_addsub #(.N(N), .PIPE_EVERY(2), .SAT_EN(0)) u_wrap (
    .CLOCK_50(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready0), .A(A), .B(B),
    .Cin(Cin), .sub(sub), .out_valid(out_valid0), .out_ready(out_ready), .Sum(Sum0),
    .Cout(Cout0), .overflow(ovf0), .zero(zero0)
  );

  lf_pipe_addsub #(.N(N), .PIPE_EVERY(2), .SAT_EN(1)) u_sat (
    .CLOCK_50(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready1), .A(A), .B(B),
    .Cin(Cin), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready), .Sum(Sum1),
    .Cout(Cout1), .overflow(ovf1), .zero(zero1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic c,
                                 input logic s);
    exp_t       m;
    logic [7:0] bb;
    logic [8:0] full;
    bb       = s ? ~b : b;
    full     = {1'b0, a} + {1'b0, bb} + {8'd0, (s ? 1'b1 : c)};
    m.sum_w  = full[7:0];
    m.cout   = full[8];
    m.ovf    = (a[7] == bb[7]) && (full[7] != a[7]);
    m.sum_s  = m.ovf ? (a[7] ? 8'h80 : 8'h7F) : full[7:0];
    m.zero_w = (m.sum_w == 8'h00);
    m.zero_s = (m.sum_s == 8'h00);
    return m;
  endfunction

  // Monitor: handshake rule, stall stability, scoreboard push/pop.
  initial begin
    logic       prev_stall, exp_rdy;
    logic [7:0] prev_sum;
    logic [2:0] prev_flags, f0, f1, ef0, ef1;
    exp_t       e;
    prev_stall = 1'b0;
    prev_sum   = '0;
    prev_flags = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        streak     = 0;
      end else begin
        exp_rdy = out_ready | ~out_valid0;
        f0      = {Cout0, ovf0, zero0};
        f1      = {Cout1, ovf1, zero1};
        check_eq("in_ready", 32'(in_ready0), 32'(exp_rdy));
        check_eq("valid_pair", 32'(out_valid1), 32'(out_valid0));
        if (prev_stall) begin
          check_eq("hold_valid", 32'(out_valid0), 32'd1);
          check_eq("hold_sum", 32'(Sum0), 32'(prev_sum));
          check_eq("hold_flags", 32'(f0), 32'(prev_flags));
        end
        if (out_valid0 && out_ready) begin
          n_out++;
          streak++;
          if (streak > max_streak) max_streak = streak;
          if (sb.size() == 0) begin
            check_eq("unexpected_out", 32'(out_valid0), 32'd0);
          end else begin
            e   = sb.pop_front();
            ef0 = {e.cout, e.ovf, e.zero_w};
            ef1 = {e.cout, e.ovf, e.zero_s};
            check_eq("sb_sum_wrap", 32'(Sum0), 32'(e.sum_w));
            check_eq("sb_flags_wrap", 32'(f0), 32'(ef0));
            check_eq("sb_sum_sat", 32'(Sum1), 32'(e.sum_s));
            check_eq("sb_flags_sat", 32'(f1), 32'(ef1));
          end
        end else begin
          streak = 0;
        end
        if (in_valid && in_ready0) sb.push_back(model(A, B, Cin, sub));
        prev_stall = out_valid0 & ~out_ready;
        prev_sum   = Sum0;
        prev_flags = f0;
      end
    end
  end

  // Present a beat at posedge+1 and hold it until accepted; returns at posedge+1.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    int n;
    n        = 0;
    A        = a;
    B        = b;
    Cin      = c;
    sub      = s;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready0 && n < 200);
    if (!in_ready0) check_eq("accept_timeout", 32'(in_ready0), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic one_beat(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic s, input logic [7:0] es0,
                          input logic [7:0] es1, input logic [2:0] ef0, input logic [2:0] ef1);
    int         n;
    logic [2:0] f0, f1;
    drive(a, b, c, s);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid0 && n < 20);
    f0 = {Cout0, ovf0, zero0};
    f1 = {Cout1, ovf1, zero1};
    check_eq({tag, "_lat"}, 32'(n), 32'd3);
    check_eq({tag, "_sum_wrap"}, 32'(Sum0), 32'(es0));
    check_eq({tag, "_sum_sat"}, 32'(Sum1), 32'(es1));
    check_eq({tag, "_flags_wrap"}, 32'(f0), 32'(ef0));
    check_eq({tag, "_flags_sat"}, 32'(f1), 32'(ef1));
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, 32'(out_valid0), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check_eq({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int base;
    logic [2:0] f0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    bp_on     = 1'b0;
    #1;
    f0 = {Cout0, ovf0, zero0};
    check_eq("reset_valid", 32'(out_valid0), 32'd0);
    check_eq("reset_sum", 32'(Sum0), 32'd0);
    check_eq("reset_flags", 32'(f0), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed beats; flags are {Cout, overflow, zero}.
    one_beat("add", 8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 8'h42, 3'b000, 3'b000);
    one_beat("sub_zero", 8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 8'h00, 3'b101, 3'b101);
    one_beat("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h7F, 3'b010, 3'b010);
    one_beat("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 3'b110, 3'b110);

    // Back-to-back stream at full throughput.
    base       = n_out;
    max_streak = 0;
    for (int i = 0; i < 16; i++) begin
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    wait_drain("stream");
    check_eq("stream_count", 32'(n_out - base), 32'd16);
    check_eq("stream_consecutive", 32'(max_streak), 32'd16);

    // Random backpressure and input gaps.
    base  = n_out;
    bp_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain("bp");
    check_eq("bp_count", 32'(n_out - base), 32'd10);

    // Reset with two beats in flight and the output stalled.
    out_ready = 1'b0;
    drive(8'h11, 8'h22, 1'b0, 1'b0);
    drive(8'h05, 8'h01, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    check_eq("stall_valid", 32'(out_valid0), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", 32'(out_valid0), 32'd0);
    check_eq("midrst_sum", 32'(Sum0), 32'd0);
    check_eq("midrst_valid_sat", 32'(out_valid1), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    one_beat("post_rst", 8'h21, 8'h12, 1'b0, 1'b0, 8'h33, 8'h33, 3'b000, 3'b000);
    repeat (4) @(posedge clk);
    #1;
    check_eq("final_idle", 32'(out_valid0), 32'd0);
    wait_drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d mismatched so far", n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lf_pipe_addsub.md
Name: lf_pipe_addsub

Overview:
- Parametrised, pipelined Ladner-Fischer prefix adder/subtractor. Successor to the combinational prefix adder.
- Adds a valid/ready stream handshake, selectable register depth through the prefix tree, per-transaction add/sub mode, optional signed saturation, and registered status flags.
- Sits in the FPU datapath; mantissa/exponent add paths feed it through the stream interface.

Parameters:
- N, 32, operand/result width in bits (N >= 2).
- PIPE_EVERY, 2, number of prefix levels per pipeline stage (>= 1).
- SAT_EN, 0, 1 = signed saturation of result on overflow; 0 = wrap.

Ports:
- CLOCK_50  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- A  in  N  operand A.
- B  in  N  operand B.
- Cin  in  1  carry-in, used only when sub=0.
- sub  in  1  1 = A-B, 0 = A+B+Cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- Sum  out  N  result.
- Cout  out  1  carry out of bit N-1 (pre-saturation).
- overflow  out  1  signed overflow, C[N]^C[N-1] (pre-saturation).
- zero  out  1  Sum == 0 (post-saturation).

Behaviour:
- Reset (asynchronous): all stage valid bits = 0, out_valid = 0, Sum = 0, Cout = 0, overflow = 0, zero = 0. In-flight beats are discarded. First accept is possible in the cycle after reset deasserts.
- Effective operands:
  - sub=1: B' = ~B and carry-in = 1; Cin is ignored.
  - sub=0: B' = B and carry-in = Cin.
  - G = A & B', P = A ^ B'.
- Prefix tree: L = clog2(N) Ladner-Fischer levels of black cells. Carries come from grey cells seeded by the effective carry-in. Sum[i] = P[i] ^ C[i].
- Pipelining:
  - Register boundary after G/P generation.
  - Register boundary after every PIPE_EVERY prefix levels.
  - The final boundary holds the carry/sum/flag outputs.
  - LAT = 1 + ceil(L/PIPE_EVERY) cycles from accept to out_valid. Example: N=8, PIPE_EVERY=2 gives LAT=3; N=32, PIPE_EVERY=2 gives LAT=4.
  - Operand bits needed downstream (P, sub) travel with their beat.
- Handshake and stall:
  - en = out_ready | ~out_valid; in_ready = en (combinational path from out_ready is allowed).
  - Accept occurs when in_valid & in_ready. Output transfers when out_valid & out_ready.
  - When en=1, all stages advance one step and stage valid bits shift. The empty slot behind a non-accepted input carries valid=0.
  - When en=0, every stage holds, including data and flags, and the outputs stay stable.
  - Full throughput is 1 beat/cycle with out_ready held at 1. Beats are never dropped, duplicated or reordered.
  - in_valid with in_ready=0 is a no-op. Upstream must hold the beat.
- Saturation (SAT_EN=1, overflow=1): Sum = A[N-1] ? {1,0...0} : {0,1...1}. Cout and overflow still report raw values. With SAT_EN=0, Sum wraps.
- Flags belong to the same beat as Sum and are valid only when out_valid=1.
- Reset mid-stream drops everything; no partial beat appears afterwards.

Test Plan:
- N=8, PIPE_EVERY=2, reset then single add A=0x3C, B=0x05, Cin=1, sub=0, out_ready=1 -> exactly 3 cycles later out_valid=1, Sum=0x42, Cout=0, overflow=0, zero=0; out_valid=0 the next cycle.
- Subtract A=0x10, B=0x10, sub=1, Cin=1 (ignored) -> Sum=0x00, zero=1, Cout=1, overflow=0.
- Overflow with SAT_EN=0, A=0x7F, B=0x01 add -> Sum=0x80, overflow=1, Cout=0. Same stimulus with SAT_EN=1 -> Sum=0x7F, overflow=1. Also A=0x80, B=0x01, sub=1, SAT_EN=1 -> Sum=0x80, overflow=1.
- Back-to-back stream of 16 random beats, in_valid=1, out_ready=1 -> 16 results on consecutive cycles in order, matching a reference model.
- Backpressure: stream 10 beats with out_ready toggling randomly and in_valid randomly gapped -> in_ready == (out_ready | ~out_valid) every cycle; Sum/flags stable while out_valid & ~out_ready; no loss, duplication or reordering.
- Assert reset mid-stream with 2 beats in flight -> out_valid=0 and Sum=0 immediately (asynchronous). After release, a new beat emerges with latency LAT and no stale beats.
